// File: rtl/mvprod_sequencer_if.sv
// ============================================================================
// Module      : mvprod_sequencer_if
// Description : Handshake and ROM/MAC control bundle of the mat-vec sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mvprod_sequencer_if #(
  parameter int IN_VEC_LENGTH  = 12,
  parameter int OUT_VEC_LENGTH = 6,
  parameter int WORKING_REGS   = 3
);
  localparam int c_N_CHUNKS = IN_VEC_LENGTH / WORKING_REGS;
  localparam int c_N_GROUPS = OUT_VEC_LENGTH / WORKING_REGS;
  localparam int c_N_WORDS  = IN_VEC_LENGTH * OUT_VEC_LENGTH / WORKING_REGS;
  localparam int c_AW = ($clog2(c_N_WORDS)    < 1) ? 1 : $clog2(c_N_WORDS);
  localparam int c_CW = ($clog2(c_N_CHUNKS)   < 1) ? 1 : $clog2(c_N_CHUNKS);
  localparam int c_LW = ($clog2(WORKING_REGS) < 1) ? 1 : $clog2(WORKING_REGS);
  localparam int c_OW = ($clog2(c_N_GROUPS)   < 1) ? 1 : $clog2(c_N_GROUPS);

  logic            start_in;
  logic            in_data_ready;
  logic            out_ack_in;
  logic            req_chunk_in;
  logic [c_AW-1:0] weight_addr;
  logic [c_CW-1:0] vec_chunk_idx;
  logic            mac_valid;
  logic            mac_clear;
  logic [c_LW-1:0] mac_lane;
  logic            req_chunk_out;
  logic [c_OW-1:0] out_chunk_idx;
  logic            busy;
  logic            out_vector_valid;

  modport master (
    output start_in, in_data_ready, out_ack_in,
    input  req_chunk_in, weight_addr, vec_chunk_idx, mac_valid, mac_clear,
           mac_lane, req_chunk_out, out_chunk_idx, busy, out_vector_valid
  );

  modport slave (
    input  start_in, in_data_ready, out_ack_in,
    output req_chunk_in, weight_addr, vec_chunk_idx, mac_valid, mac_clear,
           mac_lane, req_chunk_out, out_chunk_idx, busy, out_vector_valid
  );
endinterface

`default_nettype wire

// File: rtl/mvprod_sequencer.sv
// ============================================================================
// Module      : mvprod_sequencer
// Description : Control FSM walking the weight ROM for y = W*x, one output
//               chunk of WORKING_REGS lanes at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mvprod_sequencer #(
  parameter int IN_VEC_LENGTH  = 12,
  parameter int OUT_VEC_LENGTH = 6,
  parameter int WORKING_REGS   = 3,
  parameter int RAM_LATENCY    = 2
) (
  input  wire logic           clk_in,
  input  wire logic           rst_in,
  mvprod_sequencer_if.slave   bus
);
  localparam int c_N_CHUNKS = IN_VEC_LENGTH / WORKING_REGS;
  localparam int c_N_GROUPS = OUT_VEC_LENGTH / WORKING_REGS;
  localparam int c_N_WORDS  = IN_VEC_LENGTH * OUT_VEC_LENGTH / WORKING_REGS;
  localparam int c_AW = ($clog2(c_N_WORDS)     < 1) ? 1 : $clog2(c_N_WORDS);
  localparam int c_CW = ($clog2(c_N_CHUNKS)    < 1) ? 1 : $clog2(c_N_CHUNKS);
  localparam int c_LW = ($clog2(WORKING_REGS)  < 1) ? 1 : $clog2(WORKING_REGS);
  localparam int c_OW = ($clog2(c_N_GROUPS)    < 1) ? 1 : $clog2(c_N_GROUPS);
  localparam int c_DW = ($clog2(RAM_LATENCY+1) < 1) ? 1 : $clog2(RAM_LATENCY+1);

  localparam logic [c_CW-1:0] c_LAST_CHUNK = c_CW'(c_N_CHUNKS - 1);
  localparam logic [c_LW-1:0] c_LAST_LANE  = c_LW'(WORKING_REGS - 1);
  localparam logic [c_OW-1:0] c_LAST_GROUP = c_OW'(c_N_GROUPS - 1);
  localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(RAM_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_IN = 3'd1,
    S_ISSUE   = 3'd2,
    S_DRAIN   = 3'd3,
    S_EMIT    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t          r_state;
  logic            r_req_in;
  logic [c_AW-1:0] r_addr;
  logic [c_CW-1:0] r_chunk;
  logic [c_LW-1:0] r_lane;
  logic [c_OW-1:0] r_group;
  logic [c_DW-1:0] r_drain;
  logic            r_req_out;
  logic [c_OW-1:0] r_out_idx;
  logic            r_busy;
  logic            r_done;

  logic [RAM_LATENCY-1:0] r_pv;
  logic [RAM_LATENCY-1:0] r_pc;
  logic [c_LW-1:0]        r_pl [RAM_LATENCY];

  logic w_issue;
  logic w_last_chunk;
  logic w_last_lane;

  assign w_issue      = (r_state == S_ISSUE);
  assign w_last_chunk = (r_chunk == c_LAST_CHUNK);
  assign w_last_lane  = (r_lane  == c_LAST_LANE);

  // Rows within a group are contiguous in the ROM, so the address simply counts.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= S_IDLE;
      r_req_in  <= 1'b0;
      r_addr    <= '0;
      r_chunk   <= '0;
      r_lane    <= '0;
      r_group   <= '0;
      r_drain   <= '0;
      r_req_out <= 1'b0;
      r_out_idx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_in) begin
            r_state  <= S_WAIT_IN;
            r_req_in <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_WAIT_IN: begin
          if (bus.in_data_ready) begin
            r_state  <= S_ISSUE;
            r_req_in <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (w_last_chunk && w_last_lane) begin
            r_state <= S_DRAIN;
            r_drain <= '0;
          end else if (w_last_chunk) begin
            r_chunk <= '0;
            r_lane  <= r_lane + c_LW'(1);
            r_addr  <= r_addr + c_AW'(1);
          end else begin
            r_chunk <= r_chunk + c_CW'(1);
            r_addr  <= r_addr + c_AW'(1);
          end
        end
        S_DRAIN: begin
          if (r_drain == c_DRAIN_LAST) begin
            r_state   <= S_EMIT;
            r_req_out <= 1'b1;
            r_out_idx <= r_group;
          end else begin
            r_drain <= r_drain + c_DW'(1);
          end
        end
        S_EMIT: begin
          if (bus.out_ack_in) begin
            r_req_out <= 1'b0;
            if (r_group == c_LAST_GROUP) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
              r_group <= r_group + c_OW'(1);
              r_chunk <= '0;
              r_lane  <= '0;
              r_addr  <= r_addr + c_AW'(1);
            end
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_addr    <= '0;
          r_chunk   <= '0;
          r_lane    <= '0;
          r_group   <= '0;
          r_drain   <= '0;
          r_out_idx <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Side-band delayed to line up with ROM/buffer read data at the MAC inputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_pv <= '0;
      r_pc <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) r_pl[i] <= '0;
    end else begin
      r_pv[0] <= w_issue;
      r_pc[0] <= w_issue && (r_chunk == '0);
      r_pl[0] <= w_issue ? r_lane : '0;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pc[i] <= r_pc[i-1];
        r_pl[i] <= r_pl[i-1];
      end
    end
  end

  assign bus.req_chunk_in     = r_req_in;
  assign bus.weight_addr      = r_addr;
  assign bus.vec_chunk_idx    = r_chunk;
  assign bus.mac_valid        = r_pv[RAM_LATENCY-1];
  assign bus.mac_clear        = r_pc[RAM_LATENCY-1];
  assign bus.mac_lane         = r_pl[RAM_LATENCY-1];
  assign bus.req_chunk_out    = r_req_out;
  assign bus.out_chunk_idx    = r_out_idx;
  assign bus.busy             = r_busy;
  assign bus.out_vector_valid = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mvprod_sequencer.sv
// ============================================================================
// Module      : tb_mvprod_sequencer
// Description : Self-checking bench: cycle trace and y = W*x reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mvprod_sequencer;
  localparam int IN_L = 12;
  localparam int OUT_L = 6;
  localparam int WR = 3;
  localparam int RL = 2;
  localparam int NC = IN_L / WR;
  localparam int NG = OUT_L / WR;
  localparam int NW = IN_L * OUT_L / WR;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  mvprod_sequencer_if #(.IN_VEC_LENGTH(IN_L), .OUT_VEC_LENGTH(OUT_L), .WORKING_REGS(WR)) bus ();

  mvprod_sequencer #(
    .IN_VEC_LENGTH(IN_L), .OUT_VEC_LENGTH(OUT_L), .WORKING_REGS(WR), .RAM_LATENCY(RL)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  typedef struct {
    bit req_in; bit issue; int addr; int chunk; int lane;
    bit req_out; int oidx; bit busy; bit done; bit ack;
  } exp_t;

  typedef struct {
    int d; int a0; int a1; bit glitch; int abort_at; int exp_done;
  } vec_t;

  exp_t tr[$];
  int n_pass = 0;
  int n_total = 0;

  logic [8*WR-1:0] rom  [NW];
  logic [8*WR-1:0] vbuf [NC];
  logic [8*WR-1:0] rom_d1, rom_d2, vb_d1, vb_d2;
  int acc [WR];
  int y [OUT_L];

  function automatic int dot(input logic [8*WR-1:0] w, input logic [8*WR-1:0] x);
    int s = 0;
    for (int j = 0; j < WR; j++) s += int'(w[8*j +: 8]) * int'(x[8*j +: 8]);
    return s;
  endfunction

  // Memories with the same read latency as the real ROM and vector buffer.
  always @(posedge clk_in) begin
    rom_d1 <= rom[bus.weight_addr];
    rom_d2 <= rom_d1;
    vb_d1  <= vbuf[bus.vec_chunk_idx];
    vb_d2  <= vb_d1;
    if (bus.mac_valid)
      acc[bus.mac_lane] <= (bus.mac_clear ? 0 : acc[bus.mac_lane]) + dot(rom_d2, vb_d2);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
  endtask

  function automatic logic [15:0] pk(bit rq, int a, int v, bit mv, bit mc, int ml,
                                     bit ro, int oi, bit b, bit dn);
    return {rq, a[4:0], v[1:0], mv, mc, ml[1:0], ro, oi[0:0], b, dn};
  endfunction

  function automatic logic [15:0] act_now();
    return {bus.req_chunk_in, bus.weight_addr, bus.vec_chunk_idx, bus.mac_valid,
            bus.mac_clear, bus.mac_lane, bus.req_chunk_out, bus.out_chunk_idx,
            bus.busy, bus.out_vector_valid};
  endfunction

  // Cycle c (1-based) after the start-sampling cycle corresponds to tr[c-1].
  function automatic logic [15:0] exp_at(int c);
    exp_t e = '{default: 0};
    bit mv = 0, mc = 0;
    int ml = 0;
    int j = c - 1 - RL;
    if (c >= 1 && c <= tr.size()) e = tr[c-1];
    if (j >= 0 && j < tr.size() && tr[j].issue) begin
      mv = 1; mc = (tr[j].chunk == 0); ml = tr[j].lane;
    end
    return pk(e.req_in, e.addr, e.chunk, mv, mc, ml, e.req_out, e.oidx, e.busy, e.done);
  endfunction

  function automatic exp_t ent(bit rq, bit is, int a, int ch, int ln, bit ro, int oi,
                               bit dn, bit ak);
    exp_t e;
    e.req_in = rq; e.issue = is; e.addr = a; e.chunk = ch; e.lane = ln;
    e.req_out = ro; e.oidx = oi; e.busy = 1; e.done = dn; e.ack = ak;
    return e;
  endfunction

  task automatic build(input vec_t v);
    int ad [NG];
    int len = (v.d > 1) ? v.d : 1;
    int last;
    ad[0] = v.a0; ad[1] = v.a1;
    tr.delete();
    for (int i = 0; i < len; i++) tr.push_back(ent(1, 0, 0, 0, 0, 0, 0, 0, 1'($urandom)));
    for (int g = 0; g < NG; g++) begin
      int oi = (g == 0) ? 0 : g - 1;
      for (int k = 0; k < WR * NC; k++) begin
        int row = g * WR + k / NC;
        tr.push_back(ent(0, 1, row * NC + k % NC, k % NC, row % WR, 0, oi, 0, 1'($urandom)));
      end
      last = (g * WR + WR - 1) * NC + NC - 1;
      for (int i = 0; i < RL + 1; i++)
        tr.push_back(ent(0, 0, last, NC - 1, 0, 0, oi, 0, 1'($urandom)));
      for (int i = 0; i <= ad[g]; i++)
        tr.push_back(ent(0, 0, last, NC - 1, 0, 1, g, 0, (i == ad[g])));
    end
    tr.push_back(ent(0, 0, NW - 1, NC - 1, 0, 0, NG - 1, 1, 1'($urandom)));
    for (int i = 0; i < NW; i++) rom[i] = (8*WR)'($urandom);
    for (int i = 0; i < NC; i++) vbuf[i] = (8*WR)'($urandom);
    for (int r = 0; r < OUT_L; r++) begin
      y[r] = 0;
      for (int i = 0; i < IN_L; i++)
        y[r] += int'(rom[r * NC + i / WR][8 * (i % WR) +: 8]) * int'(vbuf[i / WR][8 * (i % WR) +: 8]);
    end
  endtask

  task automatic run(input vec_t v, input string nm);
    int n, done_cnt = 0, done_cyc = -1;
    build(v);
    n = tr.size();
    @(posedge clk_in); #1;
    bus.start_in = 1'b1; bus.in_data_ready = (v.d == 0); bus.out_ack_in = 1'b0;
    @(negedge clk_in);
    chk($sformatf("%s_idle", nm), 32'(act_now()), 32'(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    for (int c = 1; c <= n + 2; c++) begin
      @(posedge clk_in); #1;
      bus.start_in      = (v.glitch && c <= n) ? 1'($urandom) : 1'b0;
      bus.in_data_ready = (c >= v.d);
      bus.out_ack_in    = (c <= n) ? tr[c-1].ack : 1'b0;
      @(negedge clk_in);
      chk($sformatf("%s_c%0d", nm, c), 32'(act_now()), 32'(exp_at(c)));
      if (bus.out_vector_valid) begin done_cnt++; done_cyc = c; end
      if (c <= n && tr[c-1].req_out && tr[c-1].ack)
        for (int l = 0; l < WR; l++)
          chk($sformatf("%s_y%0d", nm, tr[c-1].oidx * WR + l), acc[l], y[tr[c-1].oidx * WR + l]);
      if (c == v.abort_at) begin
        #2 rst_in = 1'b0;
        #1 chk($sformatf("%s_async_rst", nm), 32'(act_now()), 32'h0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk($sformatf("%s_rst_hold", nm), 32'(act_now()), 32'h0);
        rst_in = 1'b1;
        bus.start_in = 1'b0;
        chk($sformatf("%s_no_done", nm), done_cnt, 0);
        return;
      end
    end
    chk($sformatf("%s_done_cnt", nm), done_cnt, 1);
    if (v.exp_done >= 0) chk($sformatf("%s_done_cyc", nm), done_cyc, v.exp_done);
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0] = '{0, 0, 0, 0, -1, 34};
    tbl[1] = '{10, 0, 0, 0, -1, 43};
    tbl[2] = '{0, 7, 0, 0, -1, 41};
    tbl[3] = '{3, 2, 5, 1, -1, 43};
    tbl[4] = '{0, 0, 0, 0, 8, -1};
    tbl[5] = '{1, 0, 3, 1, -1, 37};
    for (int l = 0; l < WR; l++) acc[l] = 0;
    bus.start_in = 1'b0; bus.in_data_ready = 1'b0; bus.out_ack_in = 1'b0;
    #12;
    chk("reset_state", 32'(act_now()), 32'h0);
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int t = 0; t < 6; t++) run(tbl[t], $sformatf("tbl%0d", t));
    for (int r = 0; r < 4; r++) begin
      vec_t v;
      v.d = $urandom_range(0, 6); v.a0 = $urandom_range(0, 5); v.a1 = $urandom_range(0, 5);
      v.glitch = 1'b1; v.abort_at = -1; v.exp_done = -1;
      run(v, $sformatf("rnd%0d", r));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/mvprod_sequencer.md
Name: mvprod_sequencer

Overview:
- Control FSM for the matrix-vector product datapath: one output vector y = W·x, with the weight matrix in a single-port ROM of WorkingRegs-byte words.
- Requests the input vector, then walks the weight ROM row by row, chunk by chunk.
- Issues aligned MAC strobes to WorkingRegs lane accumulators.
- Hands each finished WorkingRegs-element output chunk downstream with a req/ack handshake.

Parameters:
InVecLength, 12, input vector length in bytes; must be a multiple of WorkingRegs
OutVecLength, 6, output vector length; must be a multiple of WorkingRegs
WorkingRegs, 3, lanes per chunk; NChunks = InVecLength/WorkingRegs
RamLatency, 2, weight ROM and vector buffer read latency in cycles (HIGH_PERFORMANCE)

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous reset, active low; asserted when 0
start_in  input  1  pulse; begin one product
in_data_ready  input  1  input vector buffer holds a complete vector
out_ack_in  input  1  downstream accepted current output chunk
req_chunk_in  output  1  request input vector load
weight_addr  output  clog2(InVecLength*OutVecLength/WorkingRegs)  weight ROM address
vec_chunk_idx  output  clog2(NChunks)  input buffer chunk read index
mac_valid  output  1  ROM/buffer data at MAC inputs valid this cycle
mac_clear  output  1  with mac_valid: load the product instead of accumulating
mac_lane  output  clog2(WorkingRegs)  accumulator lane targeted by mac_valid
req_chunk_out  output  1  output chunk ready in accumulators
out_chunk_idx  output  clog2(OutVecLength/WorkingRegs)  index of the chunk offered
busy  output  1  high in every state except IDLE
out_vector_valid  output  1  one-cycle pulse; whole output vector emitted

Behaviour:
- Reset (rst_in=0, async): state IDLE; all outputs and counters 0. Reset mid-operation aborts the product, with no done pulse and no pending request.
- States: IDLE, WAIT_IN, ISSUE, DRAIN, EMIT, DONE.
- IDLE:
  - start_in=1 -> WAIT_IN.
  - start_in is ignored in every other state.
- WAIT_IN:
  - req_chunk_in=1.
  - in_data_ready=1 -> ISSUE next cycle, req_chunk_in drops.
  - in_data_ready already high on entry -> WAIT_IN lasts exactly one cycle.
- ISSUE: issues one address per cycle, with no bubbles.
  - weight_addr = row*NChunks + chunk.
  - vec_chunk_idx = chunk.
  - chunk counts 0..NChunks-1, then wraps and row increments.
  - After the last chunk of row (group*WorkingRegs + WorkingRegs-1), go to DRAIN.
- Issue side-band pipeline: an issue strobe, first-chunk flag (chunk==0) and lane (row mod WorkingRegs) are registered RamLatency cycles.
  - They emerge as mac_valid, mac_clear and mac_lane, aligned with ROM douta.
  - mac_clear is never 1 without mac_valid.
- DRAIN: exactly RamLatency+1 cycles, so the last MAC lands in the accumulators; then EMIT.
- EMIT:
  - req_chunk_out=1 and out_chunk_idx=group, held until out_ack_in=1.
  - On the ack cycle, req_chunk_out drops next cycle; group increments.
  - Go to ISSUE if rows remain, else DONE.
  - out_ack_in outside EMIT is ignored.
  - Ack in the same cycle req_chunk_out rises is legal and gives a 1-cycle EMIT.
- DONE: out_vector_valid=1 for one cycle, then IDLE. Counters are cleared on entering IDLE.
- weight_addr and vec_chunk_idx hold their last value outside ISSUE; the ROM stays enabled.
- Cycle count for one group: WorkingRegs*NChunks ISSUE + (RamLatency+1) DRAIN + at least 1 EMIT.
- Indices never exceed range: wrap is compared against the parameter-derived maximum, not the counter width.

Test Plan:
- Defaults, in_data_ready tied high, out_ack_in tied high, start pulse:
  - WAIT_IN lasts 1 cycle, then weight_addr 0..11 on consecutive cycles.
  - 3 DRAIN cycles, req_chunk_out with out_chunk_idx=0, then addresses 12..23, req_chunk_out with idx 1.
  - out_vector_valid pulses once; busy deasserts the cycle after it.
- MAC alignment: mac_valid trails each issue by exactly 2 cycles.
  - mac_clear=1 at chunks 0, 4 and 8 of each group.
  - mac_lane goes 0,0,0,0,1,1,1,1,2,2,2,2.
  - A bench model accumulating douta×vector reproduces y = W·x for a known hex weight file.
- Input handshake: in_data_ready held low 10 cycles after start -> req_chunk_in=1 for 10 cycles, no address issued, busy=1.
- Output back-pressure: out_ack_in withheld 7 cycles at group 0 -> req_chunk_out held 7 cycles, weight_addr frozen at 11, no mac_valid, group 1 starts after the ack.
- Async reset mid-ISSUE (row 1, chunk 2): all outputs 0 without a clock edge, no out_vector_valid; a subsequent start gives a clean full run from address 0.
- start_in pulsed during ISSUE and EMIT -> ignored; exactly one out_vector_valid per accepted start.
